systolic_writeback: RTL and testbench

- Downstream stage of the systolic array controller.
- Accepts one row of ARRAY_SIZE signed accumulator results per handshake.
- Rounds and saturates each lane to DATA_W, packs the lanes into one output-SRAM word, and buffers words in a small FIFO.
- Writes words to the output SRAM at base_addr + row, with SRAM back-pressure.
- Pulses wb_done after all ARRAY_SIZE rows of a tile are written.

---
 rtl/systolic_writeback_pkg.sv | 7 +
 rtl/systolic_writeback_sat_lane.sv | 23 ++
 rtl/systolic_writeback.sv | 93 +++++++++
 tb/tb_systolic_writeback.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_writeback_pkg.sv
// tpu_pkg: shared writeback state type and default datapath widths for the systolic array.
package tpu_pkg;
    localparam int TPU_DATA_W     = 16;
    localparam int TPU_ACC_W      = 32;
    localparam int TPU_ARRAY_SIZE = 8;
    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} wb_state_t;
endpackage

// File: rtl/systolic_writeback_sat_lane.sv
// wb_sat_lane: round-half-up, arithmetic shift and saturate one accumulator lane to DATA_W.
module wb_sat_lane import tpu_pkg::*; #(
    parameter int DATA_W = TPU_DATA_W,
    parameter int ACC_W  = TPU_ACC_W,
    parameter int SHIFT  = 0
) (
    input  logic [ACC_W-1:0]  acc,
    output logic [DATA_W-1:0] q,
    output logic              sat
);
    localparam logic signed [ACC_W:0] RND  = ({{ACC_W{1'b0}}, 1'b1} << SHIFT) >> 1;
    localparam logic signed [ACC_W:0] MAXV = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] MINV = {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};
    logic signed [ACC_W:0] t, s;
    logic hi, lo;
    // One guard bit keeps the rounding add from overflowing.
    assign t   = $signed({acc[ACC_W-1], acc}) + RND;
    assign s   = t >>> SHIFT;
    assign hi  = s > MAXV;
    assign lo  = s < MINV;
    assign sat = hi || lo;
    assign q   = hi ? MAXV[DATA_W-1:0] : lo ? MINV[DATA_W-1:0] : s[DATA_W-1:0];
endmodule

// File: rtl/systolic_writeback.sv
// systolic_writeback: quantise accumulator rows, buffer them and write one packed word per row to output SRAM.
module systolic_writeback import tpu_pkg::*; #(
    parameter int DATA_W     = TPU_DATA_W,
    parameter int ARRAY_SIZE = TPU_ARRAY_SIZE,
    parameter int ACC_W      = TPU_ACC_W,
    parameter int ADDR_W     = 10,
    parameter int SHIFT      = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wb_start,
    input  logic [ADDR_W-1:0]            base_addr,
    input  logic                         row_valid,
    input  logic [ARRAY_SIZE*ACC_W-1:0]  row_data,
    output logic                         row_ready,
    output logic                         sram_we,
    output logic [ADDR_W-1:0]            sram_addr,
    output logic [ARRAY_SIZE*DATA_W-1:0] sram_wdata,
    input  logic                         sram_ready,
    output logic                         wb_busy,
    output logic                         wb_done,
    output logic                         sat_flag
);
    localparam int PW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW = $clog2(ARRAY_SIZE + 1);
    localparam int WW = ARRAY_SIZE * DATA_W;

    wb_state_t         state_q;
    logic [ADDR_W-1:0] base_q;
    logic [CW-1:0]     rows_in_q, rows_out_q, rows_in_d, rows_out_d;
    logic [PW-1:0]     wr_q, rd_q;
    logic [WW-1:0]     mem_q [FIFO_DEPTH];
    logic              sat_q;
    logic [WW-1:0]     qword;
    logic [ARRAY_SIZE-1:0] lane_sat;
    logic              full, empty, push, pop;

    for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
        wb_sat_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SHIFT(SHIFT)) u_lane (
            .acc (row_data[i*ACC_W +: ACC_W]),
            .q   (qword[i*DATA_W +: DATA_W]),
            .sat (lane_sat[i])
        );
    end

    assign empty      = wr_q == rd_q;
    assign full       = (wr_q[PW-1] != rd_q[PW-1]) && (wr_q[PW-2:0] == rd_q[PW-2:0]);
    assign row_ready  = (state_q == COLLECT) && !full && (rows_in_q < CW'(ARRAY_SIZE));
    assign push       = row_valid && row_ready;
    assign sram_we    = !empty;
    assign pop        = sram_we && sram_ready;
    assign rows_in_d  = rows_in_q + CW'(push);
    assign rows_out_d = rows_out_q + CW'(pop);
    assign sram_addr  = base_q + ADDR_W'(rows_out_q);
    assign sram_wdata = empty ? '0 : mem_q[rd_q[PW-2:0]];
    assign wb_busy    = (state_q == COLLECT) || (state_q == DRAIN);
    assign wb_done    = state_q == DONE;
    assign sat_flag   = sat_q;

    always_ff @(posedge clk)
        if (push) mem_q[wr_q[PW-2:0]] <= qword;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            rows_in_q  <= '0;
            rows_out_q <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            sat_q      <= 1'b0;
        end else begin
            wr_q       <= wr_q + PW'(push);
            rd_q       <= rd_q + PW'(pop);
            rows_in_q  <= rows_in_d;
            rows_out_q <= rows_out_d;
            if (push && |lane_sat) sat_q <= 1'b1;
            case (state_q)
                IDLE:
                    if (wb_start) begin
                        base_q     <= base_addr;
                        rows_in_q  <= '0;
                        rows_out_q <= '0;
                        sat_q      <= 1'b0;
                        state_q    <= COLLECT;
                    end
                COLLECT: if (rows_in_d == CW'(ARRAY_SIZE)) state_q <= DRAIN;
                DRAIN:   if (rows_out_q == CW'(ARRAY_SIZE)) state_q <= DONE;
                DONE:    state_q <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_systolic_writeback.sv
// tb_systolic_writeback: randomized checks of two writeback instances (SHIFT 0 and 4) against an arithmetic reference model.
module tb_systolic_writeback;
    logic clk = 1'b0;
    logic rst, wb_start, row_valid, sram_ready;
    logic [9:0] base_addr;
    logic [255:0] row_data;
    logic [1:0] rr, we, busy, done, sat;
    logic [1:0][9:0] addr;
    logic [1:0][127:0] wd;

    int n_tests = 0, n_fail = 0, cyc = 0, first_acc = 0, done_cyc = 0;
    int wi, sent;
    int ri [2];
    int done_cnt [2];
    logic [1:0] tile_sat;
    logic acc_now;
    logic [9:0] tbase;
    logic [9:0] exp_a [16];
    logic [127:0] exp_d [2][16];
    logic [255:0] rows [8];

    always #5 clk = ~clk;

    systolic_writeback #(.SHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .wb_start(wb_start), .base_addr(base_addr),
        .row_valid(row_valid), .row_data(row_data), .row_ready(rr[0]),
        .sram_we(we[0]), .sram_addr(addr[0]), .sram_wdata(wd[0]), .sram_ready(sram_ready),
        .wb_busy(busy[0]), .wb_done(done[0]), .sat_flag(sat[0])
    );
    systolic_writeback #(.SHIFT(4)) dut1 (
        .clk(clk), .rst(rst), .wb_start(wb_start), .base_addr(base_addr),
        .row_valid(row_valid), .row_data(row_data), .row_ready(rr[1]),
        .sram_we(we[1]), .sram_addr(addr[1]), .sram_wdata(wd[1]), .sram_ready(sram_ready),
        .wb_busy(busy[1]), .wb_done(done[1]), .sat_flag(sat[1])
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: round half up, floor shift, clamp; returns {any_saturated, packed word}.
    function automatic logic [128:0] model(input logic [255:0] r, input int sh);
        logic [127:0] w;
        logic s;
        longint a, t;
        w = '0;
        s = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a = longint'($signed(r[i*32 +: 32]));
            t = (a + (sh > 0 ? (longint'(1) <<< (sh - 1)) : longint'(0))) >>> sh;
            if (t > 32767) begin w[i*16 +: 16] = 16'h7FFF; s = 1'b1; end
            else if (t < -32768) begin w[i*16 +: 16] = 16'h8000; s = 1'b1; end
            else w[i*16 +: 16] = t[15:0];
        end
        return {s, w};
    endfunction

    task automatic tick();
        logic [128:0] m;
        @(negedge clk);
        acc_now = 1'b0;
        if (!rst) begin
            for (int k = 0; k < 2; k++)
                if (we[k] && sram_ready) begin
                    if (ri[k] >= wi) chk($sformatf("extra_write%0d", k), we[k], 0);
                    else begin
                        chk($sformatf("addr%0d", k), addr[k], exp_a[ri[k] & 15]);
                        chk($sformatf("data%0d", k), wd[k], exp_d[k][ri[k] & 15]);
                        ri[k]++;
                    end
                end
            for (int k = 0; k < 2; k++)
                if (done[k]) begin
                    done_cnt[k]++;
                    if (k == 0) done_cyc = cyc;
                end
            if (row_valid && rr[0]) begin
                for (int k = 0; k < 2; k++) begin
                    m = model(row_data, k == 0 ? 0 : 4);
                    exp_d[k][wi & 15] = m[127:0];
                    tile_sat[k] = tile_sat[k] | m[128];
                end
                exp_a[wi & 15] = tbase + 10'(wi);
                if (wi == 0) first_acc = cyc;
                wi++;
                acc_now = 1'b1;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk({tag, "_we"}, we[k], 0);
            chk({tag, "_addr"}, addr[k], 0);
            chk({tag, "_wdata"}, wd[k], 0);
            chk({tag, "_ready"}, rr[k], 0);
            chk({tag, "_busy"}, busy[k], 0);
            chk({tag, "_done"}, done[k], 0);
            chk({tag, "_sat"}, sat[k], 0);
        end
    endtask

    task automatic start_tile(input logic [9:0] b);
        tbase = b;
        wi = 0;
        sent = 0;
        ri = '{0, 0};
        tile_sat = 2'b00;
        wb_start = 1'b1;
        base_addr = b;
        row_valid = 1'b0;
        tick();
        wb_start = 1'b0;
        base_addr = 10'($urandom);
        for (int k = 0; k < 2; k++) begin
            chk("start_busy", busy[k], 1);
            chk("start_sat_clear", sat[k], 0);
        end
    endtask

    task automatic run_tile(input int pv, input int pr);
        int d [2];
        d = done_cnt;
        for (int c = 0; c < 500 && done_cnt[0] == d[0]; c++) begin
            row_valid = sent < 8 && $urandom_range(99) < pv;
            row_data = sent < 8 ? rows[sent] : '0;
            sram_ready = $urandom_range(99) < pr;
            tick();
            if (acc_now) sent++;
        end
        row_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("done_pulse", done_cnt[k] - d[k], 1);
            chk("writes", ri[k], 8);
            chk("sat_flag", sat[k], tile_sat[k]);
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            chk("done_one_cycle", done[k], 0);
            chk("idle_busy", busy[k], 0);
        end
    endtask

    task automatic rand_rows(input int big);
        for (int r = 0; r < 8; r++)
            for (int i = 0; i < 8; i++)
                rows[r][i*32 +: 32] = (big != 0 && $urandom_range(1) == 1) ? 32'($urandom)
                                                                           : 32'($urandom_range(200000)) - 32'd100000;
    endtask

    initial begin
        logic [31:0] vals [4];
        logic [9:0] snap_a;
        logic [127:0] snap_d;
        logic have_snap;
        int d0;
        vals = '{32'h0000_0018, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFE8};
        rst = 1'b1; wb_start = 1'b0; row_valid = 1'b0; sram_ready = 1'b1;
        base_addr = '0; row_data = '0;
        done_cnt = '{0, 0}; ri = '{0, 0}; wi = 0; sent = 0; tile_sat = 2'b00; tbase = '0;
        tick();
        tick();
        chk_reset("reset");
        rst = 1'b0;

        row_valid = 1'b1;
        row_data = {8{32'h1234_5678}};
        repeat (3) begin
            tick();
            chk("idle_ready", rr[0], 0);
            chk("idle_we", we[0], 0);
        end
        row_valid = 1'b0;

        for (int r = 0; r < 8; r++)
            for (int i = 0; i < 8; i++) rows[r][i*32 +: 32] = 32'(r * 8 + i);
        start_tile(10'h010);
        run_tile(100, 100);
        chk("done_latency", done_cyc - first_acc, 10);

        for (int r = 0; r < 8; r++)
            for (int i = 0; i < 8; i++) rows[r][i*32 +: 32] = vals[(i + r) % 4];
        start_tile(10'h100);
        run_tile(100, 100);
        rand_rows(0);
        start_tile(10'h200);
        run_tile(90, 90);

        rand_rows(0);
        start_tile(10'h040);
        row_valid = 1'b1;
        sram_ready = 1'b0;
        have_snap = 1'b0;
        snap_a = '0;
        snap_d = '0;
        for (int c = 0; c < 10; c++) begin
            row_data = rows[sent];
            tick();
            if (acc_now) sent++;
            if (we[0] && have_snap) begin
                chk("bp_addr_stable", addr[0], snap_a);
                chk("bp_data_stable", wd[0], snap_d);
            end else if (we[0]) begin
                snap_a = addr[0];
                snap_d = wd[0];
                have_snap = 1'b1;
            end
        end
        chk("bp_accepts", sent, 4);
        chk("bp_ready_low", rr[0], 0);
        run_tile(100, 100);

        rand_rows(1);
        start_tile(10'h3FC);
        run_tile(70, 70);

        rand_rows(1);
        start_tile(10'h0A0);
        for (int c = 0; c < 50 && sent < 2; c++) begin
            row_valid = 1'b1;
            row_data = rows[sent];
            sram_ready = $urandom_range(1) == 1;
            tick();
            if (acc_now) sent++;
        end
        row_valid = 1'b0;
        wb_start = 1'b1;
        base_addr = 10'h155;
        tick();
        wb_start = 1'b0;
        chk("collect_start_busy", busy[0], 1);
        run_tile(80, 80);

        rand_rows(1);
        start_tile(10'h2A0);
        sram_ready = 1'b0;
        for (int c = 0; c < 50 && sent < 3; c++) begin
            row_valid = 1'b1;
            row_data = rows[sent];
            tick();
            if (acc_now) sent++;
        end
        row_valid = 1'b0;
        #2 rst = 1'b1;
        #1 chk_reset("mid_reset");
        d0 = done_cnt[0];
        tick();
        tick();
        rst = 1'b0;
        sram_ready = 1'b1;
        repeat (5) tick();
        chk("mid_reset_no_done", done_cnt[0], d0);
        chk("mid_reset_no_we", we[0], 0);
        rand_rows(1);
        start_tile(10'h123);
        run_tile(60, 60);

        repeat (3) begin
            rand_rows(1);
            start_tile(10'($urandom));
            run_tile($urandom_range(30, 100), $urandom_range(30, 100));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
